qpsk_clk_gen: RTL and testbench
===============================

Name: qpsk_clk_gen

Overview:
Parametrised successor to the fixed divide-by-256 counter. It derives the bit clock and the QPSK symbol clock from the system clock, with a runtime-programmable divide ratio, an enable, and a synchronous restart. Each clock also gets a one-cycle tick strobe, so downstream shift registers and mappers can run on clk with clock enables. It sits between the system clock and the QPSK serial-to-parallel / mapper / demapper blocks.

Parameters:
CNT_W, 8, counter and half-period width in bits.
DEFAULT_HALF, 127, half-period value loaded at reset. Bit clock period is 2*(DEFAULT_HALF+1) clk cycles.
SYM_DIV, 2, bits per symbol. Must be even and >= 2; for QPSK it is 2.
IDX_W, max(1,clog2(SYM_DIV)), width of bit_idx.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
en  in  1  count enable; when low, all state is frozen.
restart  in  1  synchronous phase restart; overrides en.
load  in  1  one-cycle strobe; captures half_in.
half_in  in  CNT_W  new half-period value (count terminal value).
clk_bit  out  1  bit clock, 50% duty.
bit_tick  out  1  one-cycle pulse on each clk_bit rising transition.
clk_sym  out  1  symbol clock; high during the first SYM_DIV/2 bits of each symbol.
sym_tick  out  1  one-cycle pulse at each symbol start, coincident with bit_tick.
bit_idx  out  IDX_W  index of the current bit within the symbol, 0..SYM_DIV-1.

Behaviour:
- Reset (async, while reset=1) sets these values:
  - count=0, hp=DEFAULT_HALF, pend_valid=0
  - clk_bit=0, clk_sym=0, bit_tick=0, sym_tick=0
  - bit_idx=SYM_DIV-1
- All outputs are registered. There is no combinational path from inputs to outputs.
- Priority per edge: restart > en.
- Restart:
  - count=0, clk_bit=0, clk_sym=0, ticks=0, bit_idx=SYM_DIV-1.
  - If pend_valid, or load in the same cycle, hp takes the new value immediately and pend_valid clears.
- en=0 and restart=0: count, clk_bit, clk_sym, bit_idx and hp hold; ticks are 0. load is still captured into pend.
- en=1, count<hp: count increments by 1; ticks are 0.
- en=1, count==hp (wrap): count becomes 0 and clk_bit toggles.
  - If clk_bit goes 0->1:
    - bit_tick=1.
    - bit_idx increments; it wraps SYM_DIV-1 -> 0.
    - On the wrap to 0, sym_tick=1.
    - clk_sym = (new bit_idx < SYM_DIV/2).
  - If clk_bit goes 1->0: ticks are 0 and bit_idx holds.
  - If pend_valid: hp = pend and pend_valid clears. The new ratio starts at a half-period boundary, which keeps the output glitch-free.
- Load/wrap interaction:
  - load in any cycle: pend=half_in, pend_valid=1.
  - load in the same cycle as a wrap: half_in goes directly to hp.
  - A later load before the wrap overwrites pend.
- Boundary cases:
  - hp=0: clk_bit toggles on every enabled cycle, giving a period of 2 clk cycles; bit_tick asserts every 2 cycles.
  - hp=2^CNT_W-1: period is 2^(CNT_W+1); count never overflows.
- count<=hp always holds because hp changes only at a wrap or a restart, when count=0.
- First edge after reset/restart with en=1: first clk_bit rise on the (hp+1)th enabled edge, with bit_tick=1, sym_tick=1, bit_idx=0, clk_sym=1.
- Reset asserted mid-operation: immediate return to reset values, including hp=DEFAULT_HALF; any pending load is lost.

Test Plan:
- Defaults, en=1 from release:
  - clk_bit rises on edge 128, falls on edge 256, period 256.
  - bit_tick pulses at edges 128, 384, 640...
  - sym_tick at 128, 640...
  - clk_sym high edges 128-383, low 384-639.
  - bit_idx alternates 0,1.
- load half_in=3 at edge 50: the current half finishes at edge 128 with no change, then clk_bit period is 8. A same-cycle wrap+load applies at that wrap.
- half_in=0 loaded and restart: clk_bit toggles every cycle; bit_tick every 2 cycles; sym_tick every 4 cycles; clk_sym period 4.
- en low for 10 cycles at count=60: count holds 60, no ticks; the next rise is delayed by exactly 10 cycles.
- restart at edge 300 with en=1: clk_bit=0, clk_sym=0, count=0; the next bit_tick and sym_tick arrive 128 edges later with bit_idx=0.
- reset pulse mid-symbol after loading 3: outputs return to zero asynchronously; after release the period is 256 again, which confirms hp=DEFAULT_HALF.

Source files
------------

// File: rtl/qpsk_clk_gen.sv
// Bit clock and QPSK symbol clock generator with a programmable half-period and
// one-cycle tick strobes, so that downstream logic can stay on the system clock.
module qpsk_clk_gen #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 127,
  parameter int SYM_DIV      = 2,
  parameter int IDX_W        = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_half_in,
  output logic             o_clk_bit,
  output logic             o_bit_tick,
  output logic             o_clk_sym,
  output logic             o_sym_tick,
  output logic [IDX_W-1:0] o_bit_idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SYM_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(SYM_DIV / 2);
  localparam logic [CNT_W-1:0] HP_RST   = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_hp;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_clk_bit;
  logic             r_clk_sym;
  logic             r_bit_tick;
  logic             r_sym_tick;
  logic [IDX_W-1:0] r_bit_idx;

  logic             w_wrap;
  logic [IDX_W-1:0] w_idx_next;

  assign w_wrap     = (r_count == r_hp);
  assign w_idx_next = (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count      <= '0;
      r_hp         <= HP_RST;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_clk_bit    <= 1'b0;
      r_clk_sym    <= 1'b0;
      r_bit_tick   <= 1'b0;
      r_sym_tick   <= 1'b0;
      r_bit_idx    <= IDX_LAST;
    end else begin
      r_bit_tick <= 1'b0;
      r_sym_tick <= 1'b0;
      if (i_restart) begin
        r_count   <= '0;
        r_clk_bit <= 1'b0;
        r_clk_sym <= 1'b0;
        r_bit_idx <= IDX_LAST;
        if (i_load) begin
          r_hp         <= i_half_in;
          r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
          r_hp         <= r_pend;
          r_pend_valid <= 1'b0;
        end
      end else begin
        if (i_load) begin
          r_pend       <= i_half_in;
          r_pend_valid <= 1'b1;
        end
        if (i_en) begin
          if (w_wrap) begin
            r_count   <= '0;
            r_clk_bit <= ~r_clk_bit;
            if (!r_clk_bit) begin
              r_bit_tick <= 1'b1;
              r_sym_tick <= (w_idx_next == '0);
              r_bit_idx  <= w_idx_next;
              r_clk_sym  <= (w_idx_next < IDX_HALF);
            end
            // Ratio changes only here (count is 0), so no half-period is ever truncated.
            if (i_load) begin
              r_hp         <= i_half_in;
              r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
              r_hp         <= r_pend;
              r_pend_valid <= 1'b0;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
      end
    end
  end

  assign o_clk_bit  = r_clk_bit;
  assign o_bit_tick = r_bit_tick;
  assign o_clk_sym  = r_clk_sym;
  assign o_sym_tick = r_sym_tick;
  assign o_bit_idx  = r_bit_idx;

endmodule

// File: tb/tb_qpsk_clk_gen.sv
// Directed bench for qpsk_clk_gen; observed vector is {clk_bit, bit_tick, sym_tick, clk_sym, bit_idx}.
module tb_qpsk_clk_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       restart;
  logic       load;
  logic [7:0] half_in;
  logic       clk_bit;
  logic       bit_tick;
  logic       clk_sym;
  logic       sym_tick;
  logic [0:0] bit_idx;
  logic [4:0] obs;

  int checks;
  int errors;

  qpsk_clk_gen #(
    .CNT_W       (8),
    .DEFAULT_HALF(127),
    .SYM_DIV     (2)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (en),
    .i_restart (restart),
    .i_load    (load),
    .i_half_in (half_in),
    .o_clk_bit (clk_bit),
    .o_bit_tick(bit_tick),
    .o_clk_sym (clk_sym),
    .o_sym_tick(sym_tick),
    .o_bit_idx (bit_idx)
  );

  assign obs = {clk_bit, bit_tick, sym_tick, clk_sym, bit_idx};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    en      = 1'b0;
    restart = 1'b0;
    load    = 1'b0;
    half_in = 8'd0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    en      = 1'b1;
    restart = 1'b0;
    load    = 1'b0;
    half_in = 8'd0;
    step(3);
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", obs, 5'b00001);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_defaults();
    do_reset();
    en = 1'b1;
    step(127);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL def_e127 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL def_e128 got %b exp %b", obs, 5'b11110); end
    step(1);
    checks++;
    if (obs !== 5'b10010) begin errors++; $display("FAIL def_e129 got %b exp %b", obs, 5'b10010); end
    step(126);
    checks++;
    if (obs !== 5'b10010) begin errors++; $display("FAIL def_e255 got %b exp %b", obs, 5'b10010); end
    step(1);
    checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL def_e256 got %b exp %b", obs, 5'b00010); end
    step(127);
    checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL def_e383 got %b exp %b", obs, 5'b00010); end
    step(1);
    checks++;
    if (obs !== 5'b11001) begin errors++; $display("FAIL def_e384 got %b exp %b", obs, 5'b11001); end
    step(1);
    checks++;
    if (obs !== 5'b10001) begin errors++; $display("FAIL def_e385 got %b exp %b", obs, 5'b10001); end
    step(255);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL def_e640 got %b exp %b", obs, 5'b11110); end
    $display("test_defaults done");
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1;
    step(49);
    load    = 1'b1;
    half_in = 8'd3;
    step(1);
    load = 1'b0;
    step(77);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL load_e127 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL load_e128 got %b exp %b", obs, 5'b11110); end
    step(3);
    checks++;
    if (obs !== 5'b10010) begin errors++; $display("FAIL load_e131 got %b exp %b", obs, 5'b10010); end
    step(1);
    checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL load_e132 got %b exp %b", obs, 5'b00010); end
    step(3);
    checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL load_e135 got %b exp %b", obs, 5'b00010); end
    step(1);
    checks++;
    if (obs !== 5'b11001) begin errors++; $display("FAIL load_e136 got %b exp %b", obs, 5'b11001); end
    step(3);
    checks++;
    if (obs !== 5'b10001) begin errors++; $display("FAIL load_e139 got %b exp %b", obs, 5'b10001); end
    // Load coincides with the wrap at edge 140, so hp=1 applies immediately.
    load    = 1'b1;
    half_in = 8'd1;
    step(1);
    load = 1'b0;
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL load_e140 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL load_e141 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL load_e142 got %b exp %b", obs, 5'b11110); end
    step(2);
    checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL load_e144 got %b exp %b", obs, 5'b00010); end
    $display("test_load done");
  endtask

  task automatic test_hp0();
    logic [4:0] exp_tab [4];
    exp_tab[0] = 5'b11110;
    exp_tab[1] = 5'b00010;
    exp_tab[2] = 5'b11001;
    exp_tab[3] = 5'b00001;
    do_reset();
    en      = 1'b1;
    restart = 1'b1;
    load    = 1'b1;
    half_in = 8'd0;
    step(1);
    restart = 1'b0;
    load    = 1'b0;
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL hp0_restart got %b exp %b", obs, 5'b00001); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (obs !== exp_tab[i % 4]) begin
        errors++;
        $display("FAIL hp0_edge%0d got %b exp %b", i + 1, obs, exp_tab[i % 4]);
      end
    end
    $display("test_hp0 done");
  endtask

  task automatic test_en_low();
    do_reset();
    en = 1'b1;
    step(60);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (obs !== 5'b00001) begin errors++; $display("FAIL enlow_hold%0d got %b exp %b", i, obs, 5'b00001); end
    end
    en = 1'b1;
    step(67);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL enlow_e137 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL enlow_e138 got %b exp %b", obs, 5'b11110); end
    $display("test_en_low done");
  endtask

  task automatic test_restart();
    do_reset();
    en = 1'b1;
    step(299);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL rst_e300 got %b exp %b", obs, 5'b00001); end
    step(127);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL rst_e427 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL rst_e428 got %b exp %b", obs, 5'b11110); end
    $display("test_restart done");
  endtask

  task automatic test_pend_restart();
    do_reset();
    en = 1'b1;
    step(9);
    load    = 1'b1;
    half_in = 8'd3;
    step(1);
    load = 1'b0;
    step(9);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL pend_e19 got %b exp %b", obs, 5'b00001); end
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(3);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL pend_after3 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL pend_after4 got %b exp %b", obs, 5'b11110); end
    $display("test_pend_restart done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    en      = 1'b1;
    restart = 1'b1;
    load    = 1'b1;
    half_in = 8'd3;
    step(1);
    restart = 1'b0;
    load    = 1'b0;
    step(6);
    checks++;
    if (obs !== 5'b10010) begin errors++; $display("FAIL mid_before got %b exp %b", obs, 5'b10010); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL mid_async got %b exp %b", obs, 5'b00001); end
    step(1);
    reset = 1'b0;
    step(4);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL mid_e4 got %b exp %b", obs, 5'b00001); end
    step(123);
    checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL mid_e127 got %b exp %b", obs, 5'b00001); end
    step(1);
    checks++;
    if (obs !== 5'b11110) begin errors++; $display("FAIL mid_e128 got %b exp %b", obs, 5'b11110); end
    $display("test_reset_mid done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_defaults();
    test_load();
    test_hp0();
    test_en_low();
    test_restart();
    test_pend_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
